// File: rtl/iram_responder.sv
// Instruction-memory responder: slave end of the PC-stage fetch interface.
// Grants one fetch at a time, answers after WAIT_CYC wait states, and owns a loader-filled word array.
module iram_responder #(
    parameter int XLEN       = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int WAIT_CYC   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_req,
    input  logic [XLEN-1:0] inst_addr,
    output logic            inst_gnt,
    output logic            inst_rvalid,
    output logic [XLEN-1:0] inst_rdata,
    output logic            inst_rerr,
    input  logic            flush,
    input  logic            ld_we,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [XLEN-1:0] ld_wdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int WAIT_M1 = (WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0;
    localparam logic [3:0] WAIT_INIT = WAIT_M1[3:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // A fetch address is unusable if misaligned or beyond the array.
    function automatic logic addr_err(input logic [XLEN-1:0] a);
        addr_err = (a[1:0] != 2'b00) || (a[XLEN-1:DEPTH_LOG2+2] != '0);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [XLEN-1:0] a);
        word_idx = a[DEPTH_LOG2+1:2];
    endfunction

    logic [XLEN-1:0] mem_q [DEPTH];

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            rvalid_q, rvalid_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            rerr_q, rerr_d;

    logic            grant_s;
    logic            enter_resp_s;
    logic [XLEN-1:0] rd_addr_s;
    logic            rd_err_s;
    logic            ld_in_range_s;
    logic            unused_s;

    assign unused_s      = ^ld_addr[1:0];
    assign ld_in_range_s = (ld_addr[XLEN-1:DEPTH_LOG2+2] == '0);

    // Grant handshake: a RESP cycle may accept the next fetch, flush always blocks it.
    always_comb begin
        grant_s = inst_req & ~flush & ((state_q == ST_IDLE) | (state_q == ST_RESP));
    end

    // Transaction FSM: next state, wait counter, latched address and RESP entry.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        enter_resp_s = 1'b0;
        rd_addr_s    = addr_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (grant_s) begin
                    addr_d = inst_addr;
                    if (WAIT_CYC == 0) begin
                        // Zero wait states: the array is read from the address being latched.
                        state_d      = ST_RESP;
                        cnt_d        = 4'd0;
                        enter_resp_s = 1'b1;
                        rd_addr_s    = inst_addr;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response datapath: rdata is captured only when entering RESP and held otherwise.
    always_comb begin
        rd_err_s = addr_err(rd_addr_s);
        rvalid_d = enter_resp_s;
        rerr_d   = enter_resp_s & rd_err_s;
        rdata_d  = rdata_q;
        if (enter_resp_s) begin
            if (rd_err_s) begin
                rdata_d = '0;
            end else begin
                rdata_d = mem_q[word_idx(rd_addr_s)];
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Control and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

    // Loader write port; the fetch read above sees the pre-write word on the same edge.
    always_ff @(posedge clk) begin
        if (ld_we && ld_in_range_s) begin
            mem_q[word_idx(ld_addr)] <= ld_wdata;
        end
    end

    assign inst_gnt    = grant_s;
    assign inst_rvalid = rvalid_q;
    assign inst_rdata  = rdata_q;
    assign inst_rerr   = rerr_q;

endmodule

// File: tb/tb_iram_responder.sv
// Directed bench for iram_responder: three instances (0, 2, 3 wait states) share one stimulus stream.
module tb_iram_responder;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;

    logic        gnt0, rv0, re0;
    logic [31:0] rd0;
    logic        gnt2, rv2, re2;
    logic [31:0] rd2;
    logic        gnt3, rv3, re3;
    logic [31:0] rd3;

    int n_vec  = 0;
    int n_miss = 0;

    iram_responder #(.XLEN(32), .DEPTH_LOG2(12), .WAIT_CYC(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .inst_req(req), .inst_addr(addr),
        .inst_gnt(gnt0), .inst_rvalid(rv0), .inst_rdata(rd0), .inst_rerr(re0),
        .flush(flush), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata)
    );

    iram_responder #(.XLEN(32), .DEPTH_LOG2(12), .WAIT_CYC(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .inst_req(req), .inst_addr(addr),
        .inst_gnt(gnt2), .inst_rvalid(rv2), .inst_rdata(rd2), .inst_rerr(re2),
        .flush(flush), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata)
    );

    iram_responder #(.XLEN(32), .DEPTH_LOG2(12), .WAIT_CYC(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .inst_req(req), .inst_addr(addr),
        .inst_gnt(gnt3), .inst_rvalid(rv3), .inst_rdata(rd3), .inst_rerr(re3),
        .flush(flush), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs just after the falling edge, then settle before checks.
    task automatic cyc(input logic r, input logic [31:0] a, input logic f);
        @(negedge clk);
        req   = r;
        addr  = a;
        flush = f;
        ld_we = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; addr = 32'h0; flush = 1'b0;
        ld_we = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;

        // reset state
        idle(2);
        chk("rst_rv0", {31'd0, rv0}, 32'd0);
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_re0", {31'd0, re0}, 32'd0);
        chk("rst_rv3", {31'd0, rv3}, 32'd0);
        chk("rst_rd3", rd3, 32'h0);
        rst_n = 1'b1;

        // preload words 0..31 with 0x1000_0000 + k
        for (int k = 0; k < 32; k++) begin
            cyc(1'b0, 32'h0, 1'b0);
            ld_we    = 1'b1;
            ld_addr  = k * 4;
            ld_wdata = 32'h1000_0000 + k;
        end
        idle(2);

        // back-to-back fetches, zero wait states
        cyc(1'b1, 32'h0, 1'b0);
        chk("t1_gnt_c0", {31'd0, gnt0}, 32'd1);
        chk("t1_rv_c0", {31'd0, rv0}, 32'd0);
        cyc(1'b1, 32'h4, 1'b0);
        chk("t1_gnt_c1", {31'd0, gnt0}, 32'd1);
        chk("t1_rv_c1", {31'd0, rv0}, 32'd1);
        chk("t1_rd_c1", rd0, 32'h1000_0000);
        cyc(1'b1, 32'h8, 1'b0);
        chk("t1_rv_c2", {31'd0, rv0}, 32'd1);
        chk("t1_rd_c2", rd0, 32'h1000_0001);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t1_gnt_c3", {31'd0, gnt0}, 32'd0);
        chk("t1_rv_c3", {31'd0, rv0}, 32'd1);
        chk("t1_rd_c3", rd0, 32'h1000_0002);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t1_rv_c4", {31'd0, rv0}, 32'd0);
        idle(6);

        // request together with flush in IDLE: flush wins
        cyc(1'b1, 32'h10, 1'b1);
        chk("fl_gnt0", {31'd0, gnt0}, 32'd0);
        chk("fl_gnt2", {31'd0, gnt2}, 32'd0);
        chk("fl_gnt3", {31'd0, gnt3}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("fl_rv0", {31'd0, rv0}, 32'd0);
        idle(2);

        // two wait states, request held high through WAIT
        cyc(1'b1, 32'h10, 1'b0);
        chk("t2_gnt_T", {31'd0, gnt2}, 32'd1);
        cyc(1'b1, 32'h10, 1'b0);
        chk("t2_gnt_T1", {31'd0, gnt2}, 32'd0);
        chk("t2_rv_T1", {31'd0, rv2}, 32'd0);
        cyc(1'b1, 32'h10, 1'b0);
        chk("t2_gnt_T2", {31'd0, gnt2}, 32'd0);
        chk("t2_rv_T2", {31'd0, rv2}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t2_rv_T3", {31'd0, rv2}, 32'd1);
        chk("t2_rd_T3", rd2, 32'h1000_0004);
        chk("t2_re_T3", {31'd0, re2}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t2_rv_T4", {31'd0, rv2}, 32'd0);
        idle(6);

        // three wait states, flush in WAIT, then a fresh fetch
        cyc(1'b1, 32'h20, 1'b0);
        chk("t3_gnt_a", {31'd0, gnt3}, 32'd1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("t3_gnt_fl", {31'd0, gnt3}, 32'd0);
        chk("t3_rv_c1", {31'd0, rv3}, 32'd0);
        cyc(1'b1, 32'h40, 1'b0);
        chk("t3_gnt_b", {31'd0, gnt3}, 32'd1);
        chk("t3_rv_c2", {31'd0, rv3}, 32'd0);
        for (int i = 3; i <= 5; i++) begin
            cyc(1'b0, 32'h0, 1'b0);
            chk($sformatf("t3_rv_c%0d", i), {31'd0, rv3}, 32'd0);
        end
        cyc(1'b0, 32'h0, 1'b0);
        chk("t3_rv_c6", {31'd0, rv3}, 32'd1);
        chk("t3_rd_c6", rd3, 32'h1000_0010);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t3_rv_c7", {31'd0, rv3}, 32'd0);
        idle(6);

        // error responses: misaligned, then out of range
        cyc(1'b1, 32'h6, 1'b0);
        chk("t4_gnt", {31'd0, gnt0}, 32'd1);
        cyc(1'b1, 32'h4000, 1'b0);
        chk("t4_rv_mis", {31'd0, rv0}, 32'd1);
        chk("t4_re_mis", {31'd0, re0}, 32'd1);
        chk("t4_rd_mis", rd0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t4_rv_oor", {31'd0, rv0}, 32'd1);
        chk("t4_re_oor", {31'd0, re0}, 32'd1);
        chk("t4_rd_oor", rd0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t4_rv_end", {31'd0, rv0}, 32'd0);
        chk("t4_re_end", {31'd0, re0}, 32'd0);
        idle(6);

        // loader write to word 5 on the edge that enters RESP for 0x14
        cyc(1'b1, 32'h14, 1'b0);
        ld_we = 1'b1; ld_addr = 32'h14; ld_wdata = 32'hDEAD_BEEF;
        chk("t5_gnt", {31'd0, gnt0}, 32'd1);
        cyc(1'b1, 32'h14, 1'b0);
        chk("t5_rv_old", {31'd0, rv0}, 32'd1);
        chk("t5_rd_old", rd0, 32'h1000_0005);
        cyc(1'b0, 32'h0, 1'b0);
        ld_we = 1'b1; ld_addr = 32'h4014; ld_wdata = 32'h1234_5678;
        chk("t5_rv_new", {31'd0, rv0}, 32'd1);
        chk("t5_rd_new", rd0, 32'hDEAD_BEEF);
        cyc(1'b1, 32'h14, 1'b0);
        chk("t5_rv_gap", {31'd0, rv0}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("t5_rv_oorld", {31'd0, rv0}, 32'd1);
        chk("t5_rd_oorld", rd0, 32'hDEAD_BEEF);
        idle(6);

        // reset during WAIT drops the fetch
        cyc(1'b1, 32'h8, 1'b0);
        chk("t6_gnt_a", {31'd0, gnt2}, 32'd1);
        cyc(1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        chk("t6_rv_rst", {31'd0, rv2}, 32'd0);
        chk("t6_rd_rst", rd2, 32'h0);
        chk("t6_re_rst", {31'd0, re2}, 32'd0);
        chk("t6_rd0_rst", rd0, 32'h0);
        for (int i = 3; i <= 4; i++) begin
            cyc(1'b0, 32'h0, 1'b0);
            chk($sformatf("t6_rv_c%0d", i), {31'd0, rv2}, 32'd0);
        end
        cyc(1'b1, 32'hC, 1'b0);
        chk("t6_gnt_b", {31'd0, gnt2}, 32'd1);
        for (int i = 6; i <= 7; i++) begin
            cyc(1'b0, 32'h0, 1'b0);
            chk($sformatf("t6_rv_c%0d", i), {31'd0, rv2}, 32'd0);
        end
        cyc(1'b0, 32'h0, 1'b0);
        chk("t6_rv_resp", {31'd0, rv2}, 32'd1);
        chk("t6_rd_resp", rd2, 32'h1000_0003);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/iram_responder.md
Name: iram_responder

Overview:
- Instruction-memory responder: the slave end of the fetch request interface driven by the PC stage.
- Accepts one fetch request at a time via inst_req/inst_addr and returns a grant (inst_gnt, the fetch handshake-success strobe).
- Returns a single-cycle response (inst_rvalid/inst_rdata/inst_rerr) after a programmable number of wait states.
- Holds a word-addressed instruction array, filled by a loader write port; supports flush to discard an in-flight fetch on redirect (branch, exception, mret).

Parameters:
- XLEN, 32, data/address width.
- DEPTH_LOG2, 12, log2 of array depth in words.
- WAIT_CYC, 0, extra wait states per fetch (0..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- inst_req  in  1  fetch request (iram_en from PC stage).
- inst_addr  in  XLEN  byte address of fetch (pc).
- inst_gnt  out  1  request accepted this cycle (fetch handshake success).
- inst_rvalid  out  1  response valid, one-cycle pulse.
- inst_rdata  out  XLEN  fetched instruction.
- inst_rerr  out  1  fetch error (misaligned or out of range), qualified by inst_rvalid.
- flush  in  1  discard outstanding fetch.
- ld_we  in  1  loader write enable.
- ld_addr  in  XLEN  loader byte address (word index = ld_addr[DEPTH_LOG2+1:2]).
- ld_wdata  in  XLEN  loader write data.

Behaviour:
- Reset (clk edge with rst_n=0): state IDLE, wait counter 0, inst_rvalid 0, inst_rdata 0, inst_rerr 0, latched address 0. Array contents are not reset. Reset mid-transaction drops the transaction with no response.
- States:
  - IDLE: no transaction outstanding.
  - WAIT: counting wait states.
  - RESP: inst_rvalid=1 this cycle.
- Grant (combinational): inst_gnt = inst_req & ~flush & (state==IDLE | state==RESP).
  - A new grant is permitted in the RESP cycle, giving one fetch per (WAIT_CYC+1) cycles.
- On grant:
  - Latch inst_addr.
  - If WAIT_CYC==0, go to RESP; otherwise go to WAIT with counter=WAIT_CYC-1.
- WAIT: if counter==0, go to RESP; otherwise decrement the counter.
- Latency: grant at edge T gives inst_rvalid high during cycle T+1+WAIT_CYC, for exactly one cycle. There is no back-pressure; the fetch stage must consume the response.
- RESP exit: go to IDLE unless a new grant occurs in the same cycle; in that case take the grant transition.
- Read data:
  - inst_rdata is registered on the edge entering RESP, from the array word at latched_addr[DEPTH_LOG2+1:2].
  - inst_rdata holds its value outside RESP.
  - inst_rvalid is driven only in RESP.
- Errors:
  - inst_rerr=1 with inst_rvalid when latched_addr[1:0]!=0 or latched_addr[XLEN-1:DEPTH_LOG2+2]!=0.
  - On error, inst_rdata=0 and the array is not read.
- Flush:
  - In WAIT: go to IDLE, counter cleared, no response generated.
  - On the edge that would enter RESP: that entry is suppressed.
  - In RESP: inst_rvalid is still shown that cycle (already registered) but no grant is possible. The fetch stage ignores it because flush redirects the PC.
  - In IDLE: only blocks the grant.
- Loader:
  - ld_we writes ld_wdata to the array word at any time, independent of state.
  - Out-of-range ld_addr (upper bits nonzero) is ignored.
  - If a write and a read to the same word occur on the same edge, the read returns the old data (read-before-write).
- Simultaneous inst_req and flush: flush wins, no grant.
- Invariant: at most one outstanding transaction at any time.

Test Plan:
- WAIT_CYC=0, array preloaded with word k = 0x1000_0000+k, inst_req held high from addr 0x0 stepping +4 each grant → inst_gnt every cycle; rvalid every cycle from the second; rdata sequence 0x1000_0000, 0x1000_0001, 0x1000_0002.
- WAIT_CYC=2, single request addr 0x10 granted at edge T → inst_rvalid only in cycle T+3, rdata=0x1000_0004; inst_gnt=0 in cycles T+1 and T+2.
- WAIT_CYC=3, request 0x20, flush one cycle after the grant, new request 0x40 on the next cycle → no rvalid for 0x20; 0x40 granted; rvalid 4 cycles later with rdata=0x1000_0010.
- Misaligned addr 0x6, and addr 0x4000 with DEPTH_LOG2=12 → inst_rvalid=1, inst_rerr=1, inst_rdata=0 for each.
- Loader writes 0xDEAD_BEEF to word 5 on the same edge that enters RESP for addr 0x14 → rdata returns the old value; a repeat fetch returns 0xDEAD_BEEF.
- rst_n low for one cycle during WAIT (WAIT_CYC=2) → no rvalid afterwards; all outputs 0; next request is served normally.
